// File: rtl/mac_pkg.sv
// Shared types and constants for the FloatSD4 MAC pipeline sequencer.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  localparam int MAC_PIPE_DEPTH = 5;
  localparam int MAC_OUT_W      = 16;

  // Number of operations issued but not yet retired (modulo counter width).
  function automatic logic [31:0] mac_in_flight(input logic [31:0] issued,
                                                input logic [31:0] retired);
    return issued - retired;
  endfunction

endpackage

// File: rtl/mac_out_reg.sv
// One-entry output register for stage-5 results: capture, downstream drain
// and generation of the global pipeline stall.
module mac_out_reg
  import mac_pkg::*;
#(
  parameter int OUT_W = MAC_OUT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_cap_en,
  input  logic             i_mac_valid,
  input  logic [OUT_W-1:0] i_conv,
  input  logic             i_out_ready,
  output logic             o_inhibit,
  output logic             o_capture,
  output logic             o_out_valid,
  output logic [OUT_W-1:0] o_out_data
);

  logic             full_q, full_d;
  logic [OUT_W-1:0] data_q, data_d;

  // Stall only while a held result cannot leave; an empty or draining
  // register lets the whole pipeline advance.
  assign o_inhibit = full_q & ~i_out_ready;
  assign o_capture = i_mac_valid & ~o_inhibit & i_cap_en;

  always_comb begin
    full_d = o_capture | (full_q & ~i_out_ready);
    data_d = data_q;
    if (o_capture) begin
      data_d = i_conv;
    end
    if (i_clear) begin
      full_d = 1'b0;
      data_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_out_valid = full_q;
  assign o_out_data  = data_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 5-stage FloatSD4 MAC pipeline: issues N operands,
// tracks retirements, drives the shared stall and signals job completion.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int OUT_W = MAC_OUT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_ops,
  input  logic             i_abort,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  output logic             o_mac_valid,
  output logic             o_inhibit,
  input  logic             i_mac_valid,
  input  logic [OUT_W-1:0] i_conv,
  output logic             o_out_valid,
  output logic [OUT_W-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_ops_q, num_ops_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;

  logic             capture;
  logic             issue;
  logic [CNT_W-1:0] in_flight;

  mac_out_reg #(
    .OUT_W (OUT_W)
  ) u_out_reg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_abort),
    .i_cap_en    (state_q != ST_IDLE),
    .i_mac_valid (i_mac_valid),
    .i_conv      (i_conv),
    .i_out_ready (i_out_ready),
    .o_inhibit   (o_inhibit),
    .o_capture   (capture),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data)
  );

  assign in_flight   = CNT_W'(mac_in_flight(32'(issued_q), 32'(retired_q)));
  assign o_op_ready  = (state_q == ST_RUN) & (issued_q < num_ops_q) & ~o_inhibit;
  assign issue       = i_op_valid & o_op_ready;
  assign o_mac_valid = issue;

  always_comb begin
    state_d   = state_q;
    num_ops_d = num_ops_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    err_d     = err_q;

    if (issue) begin
      issued_d = issued_q + CNT_W'(1);
    end
    // A result with nothing outstanding is kept in the register but is not
    // counted, so the job still waits for its real retirements.
    if (capture) begin
      if (in_flight == '0) begin
        err_d = 1'b1;
      end else begin
        retired_d = retired_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_ops_d = i_num_ops;
          issued_d  = '0;
          retired_d = '0;
          err_d     = 1'b0;
          state_d   = (i_num_ops == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && (issued_d == num_ops_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((retired_q == num_ops_q) && !o_out_valid && !capture) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_abort) begin
      state_d   = ST_IDLE;
      num_ops_d = '0;
      issued_d  = '0;
      retired_d = '0;
      err_d     = err_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      num_ops_q <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_ops_q <= num_ops_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a stalling 5-deep pipeline model feeds results back
// and a FIFO scoreboard checks every accepted output against issue order.
module tb_mac_seq_ctrl;

  localparam int CNT_W = 10;
  localparam int OUT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic [CNT_W-1:0] i_num_ops;
  logic             i_abort;
  logic             i_op_valid;
  logic             o_op_ready;
  logic             o_mac_valid;
  logic             o_inhibit;
  logic             i_mac_valid;
  logic [OUT_W-1:0] i_conv;
  logic             o_out_valid;
  logic [OUT_W-1:0] o_out_data;
  logic             i_out_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  mac_seq_ctrl #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_num_ops   (i_num_ops),
    .i_abort     (i_abort),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .o_mac_valid (o_mac_valid),
    .o_inhibit   (o_inhibit),
    .i_mac_valid (i_mac_valid),
    .i_conv      (i_conv),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // pipeline model and scoreboard
  bit               pv[5];
  logic [OUT_W-1:0] pd[5];
  logic [OUT_W-1:0] exp_q[$];
  bit               inj = 1'b0;

  // per-scenario observations
  int cyc, issue_cnt, sb_got, sb_bad, done_cnt, inh_cnt, inh_bad, mv_bad, ov_cnt;
  int first_issue, last_issue, first_ov;

  task automatic clear_obs();
    issue_cnt = 0; sb_got = 0; sb_bad = 0; done_cnt = 0; inh_cnt = 0;
    inh_bad = 0; mv_bad = 0; ov_cnt = 0;
    first_issue = -1; last_issue = -1; first_ov = -1;
    exp_q.delete();
  endtask

  // One clock: observe outputs mid-cycle, then advance the pipeline model.
  task automatic cycle();
    logic mv, inh, ov, rdy;
    logic [OUT_W-1:0] od, tag;
    #1;
    mv  = o_mac_valid; inh = o_inhibit; ov = o_out_valid;
    od  = o_out_data;  rdy = i_out_ready;
    tag = '0;
    if (inh !== (ov & ~rdy)) inh_bad++;
    if (mv !== (i_op_valid & o_op_ready)) mv_bad++;
    if (o_op_ready === 1'b1 && inh === 1'b1) mv_bad++;
    if (inh === 1'b1) inh_cnt++;
    if (o_done === 1'b1) done_cnt++;
    if (ov === 1'b1) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = cyc;
    end
    if (ov === 1'b1 && rdy === 1'b1) begin
      sb_got++;
      if (exp_q.size() == 0) sb_bad++;
      else begin
        if (od !== exp_q[0]) sb_bad++;
        void'(exp_q.pop_front());
      end
    end
    if (inj && !inh) exp_q.push_back(i_conv);
    if (mv === 1'b1) begin
      tag = OUT_W'($urandom);
      exp_q.push_back(tag);
      issue_cnt++;
      if (first_issue < 0) first_issue = cyc;
      last_issue = cyc;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (!inh) begin
      for (int s = 4; s > 0; s--) begin
        pv[s] = pv[s-1];
        pd[s] = pd[s-1];
      end
      pv[0] = mv;
      pd[0] = tag;
    end
    i_mac_valid = pv[4];
    i_conv      = pd[4];
  endtask

  task automatic idle(input int n);
    i_op_valid = 1'b0; i_out_ready = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b1; i_num_ops = 10'd5; i_abort = 1'b0;
    i_op_valid = 1'b0; i_out_ready = 1'b1; i_mac_valid = 1'b0; i_conv = '0;
    cycle(); cycle();
    checks++; if (o_op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready: got %b want 0", o_op_ready); end
    checks++; if (o_mac_valid !== 1'b0) begin errors++; $display("FAIL rst_mac_valid: got %b want 0", o_mac_valid); end
    checks++; if (o_inhibit !== 1'b0) begin errors++; $display("FAIL rst_inhibit: got %b want 0", o_inhibit); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", o_out_valid); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", o_out_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", o_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
    i_rst_n = 1'b1; i_start = 1'b0;
    cycle();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: busy=%b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    i_start = 1'b1; i_num_ops = 10'd4; i_op_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_start = 1'b0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", o_busy); end
    for (int k = 0; k < 60 && done_cnt == 0; k++) cycle();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after_done: got %b want 0", o_busy); end
    i_op_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    checks++; if (issue_cnt != 4) begin errors++; $display("FAIL b2b_issues: got %0d want 4", issue_cnt); end
    checks++; if (last_issue - first_issue != 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", last_issue - first_issue); end
    checks++; if (first_ov - first_issue != 6) begin errors++; $display("FAIL b2b_latency: got %0d want 6", first_ov - first_issue); end
    checks++; if (sb_got != 4 || sb_bad != 0) begin errors++; $display("FAIL b2b_results: got=%0d bad=%0d want 4/0", sb_got, sb_bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_once: got %0d want 1", done_cnt); end
    checks++; if (mv_bad != 0 || inh_bad != 0) begin errors++; $display("FAIL b2b_comb: mv_bad=%0d inh_bad=%0d want 0", mv_bad, inh_bad); end
  endtask

  task automatic test_stall();
    clear_obs();
    i_start = 1'b1; i_num_ops = 10'd6; i_op_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int k = 0; k < 80 && done_cnt == 0; k++) begin
      i_out_ready = !(first_ov >= 0 && cyc >= first_ov + 2 && cyc <= first_ov + 4);
      i_start     = (first_issue >= 0 && cyc == first_issue + 2);
      i_num_ops   = i_start ? 10'd1 : 10'd6;
      cycle();
    end
    idle(4);
    checks++; if (inh_cnt != 3) begin errors++; $display("FAIL stall_inhibit_cycles: got %0d want 3", inh_cnt); end
    checks++; if (sb_got != 6 || sb_bad != 0) begin errors++; $display("FAIL stall_results: got=%0d bad=%0d want 6/0", sb_got, sb_bad); end
    checks++; if (issue_cnt != 6) begin errors++; $display("FAIL stall_issues: got %0d want 6", issue_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_once: got %0d want 1", done_cnt); end
    checks++; if (mv_bad != 0 || inh_bad != 0) begin errors++; $display("FAIL stall_comb: mv_bad=%0d inh_bad=%0d want 0", mv_bad, inh_bad); end
  endtask

  task automatic test_zero_len();
    clear_obs();
    i_start = 1'b1; i_num_ops = 10'd0; i_op_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_start = 1'b0;
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_done_t1: got %b want 1", o_done); end
    cycle();
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL zero_idle_t2: busy=%b done=%b want 0/0", o_busy, o_done); end
    for (int k = 0; k < 4; k++) cycle();
    checks++; if (issue_cnt != 0) begin errors++; $display("FAIL zero_no_issue: got %0d want 0", issue_cnt); end
    idle(2);
  endtask

  task automatic test_abort();
    clear_obs();
    i_start = 1'b1; i_num_ops = 10'd4; i_op_valid = 1'b1; i_out_ready = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int k = 0; k < 40 && !(issue_cnt == 4 && sb_got == 1); k++) cycle();
    i_op_valid = 1'b0;
    i_abort = 1'b1;
    cycle();
    i_abort = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b out_valid=%b want 0/0", o_busy, o_out_valid); end
    exp_q.delete();
    ov_cnt = 0;
    for (int k = 0; k < 6; k++) cycle();
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL abort_discard: out_valid cycles=%0d want 0", ov_cnt); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", o_err); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_err();
    logic [OUT_W-1:0] d;
    clear_obs();
    d = OUT_W'($urandom);
    i_start = 1'b1; i_num_ops = 10'd3; i_op_valid = 1'b0; i_out_ready = 1'b1;
    cycle();
    i_start = 1'b0;
    inj = 1'b1; i_mac_valid = 1'b1; i_conv = d;
    cycle();
    inj = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", o_err); end
    checks++; if (o_out_valid !== 1'b1 || o_out_data !== d) begin errors++; $display("FAIL err_registered: valid=%b data=%h want 1/%h", o_out_valid, o_out_data, d); end
    for (int k = 0; k < 3; k++) cycle();
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b busy=%b want 1/1", o_err, o_busy); end
    i_abort = 1'b1;
    cycle();
    i_abort = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_after_abort: got %b want 1", o_err); end
    i_start = 1'b1; i_num_ops = 10'd0;
    cycle();
    i_start = 1'b0;
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_start: got %b want 0", o_err); end
    checks++; if (sb_got != 1 || sb_bad != 0) begin errors++; $display("FAIL err_result: got=%0d bad=%0d want 1/0", sb_got, sb_bad); end
    idle(3);
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 4; j++) begin
      clear_obs();
      n = int'($urandom_range(12, 1));
      i_start = 1'b1; i_num_ops = CNT_W'(n); i_op_valid = 1'b0; i_out_ready = 1'b1;
      cycle();
      i_start = 1'b0;
      for (int k = 0; k < 500 && done_cnt == 0; k++) begin
        i_op_valid  = ($urandom % 4) != 0;
        i_out_ready = ($urandom % 3) != 0;
        cycle();
      end
      idle(3);
      checks++; if (issue_cnt != n) begin errors++; $display("FAIL rnd%0d_issues: got %0d want %0d", j, issue_cnt, n); end
      checks++; if (sb_got != n || sb_bad != 0) begin errors++; $display("FAIL rnd%0d_results: got=%0d bad=%0d want %0d/0", j, sb_got, sb_bad, n); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_once: got %0d want 1", j, done_cnt); end
      checks++; if (mv_bad != 0 || inh_bad != 0) begin errors++; $display("FAIL rnd%0d_comb: mv_bad=%0d inh_bad=%0d want 0", j, mv_bad, inh_bad); end
    end
  endtask

  initial begin
    cyc = 0;
    for (int s = 0; s < 5; s++) begin pv[s] = 1'b0; pd[s] = '0; end
    clear_obs();
    test_reset();
    idle(2);
    test_back_to_back();
    idle(3);
    test_stall();
    test_zero_len();
    test_abort();
    idle(3);
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
